datapath_controller: RTL and testbench

- Moore FSM control unit that sequences the 16-bit datapath (register file, data memory, write-back mux, ALU) one instruction at a time.
- Owns the program counter (PC) and instruction register (IR).
- Drives the instruction-ROM address; decodes the 4-bit opcode; issues every datapath select/enable: D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB, ALU_s0.
- Sits between the instruction ROM and the datapath; top level of the processor core.

---
 rtl/datapath_ctrl_pkg.sv | 90 +++++++++
 rtl/datapath_controller_pc_ir_reg.sv | 26 ++
 rtl/datapath_controller.sv | 76 +++++++
 tb/tb_datapath_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared types, opcodes and FSM helper functions for datapath_controller
package datapath_ctrl_pkg;

  // State encodings are exported unchanged on state_out
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Datapath control bundle; one value per FSM state
  typedef struct packed {
    logic       d_wr;
    logic       rf_sel;
    logic       rf_w_en;
    logic [2:0] alu_s0;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{d_wr: 1'b0, rf_sel: 1'b0, rf_w_en: 1'b0,
                                  alu_s0: ALU_PASS, halted: 1'b0};

  // Successor state; undefined opcodes fall into NOOP
  function automatic state_t next_state(input state_t cur, input logic [3:0] op);
    state_t nxt;
    nxt = ST_INIT;
    case (cur)
      ST_INIT:   nxt = ST_FETCH;
      ST_FETCH:  nxt = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_STORE: nxt = ST_STORE;
          OP_LOAD:  nxt = ST_LOAD_A;
          OP_ADD:   nxt = ST_ADD;
          OP_SUB:   nxt = ST_SUB;
          OP_HALT:  nxt = ST_HALT;
          default:  nxt = ST_NOOP;
        endcase
      end
      ST_LOAD_A: nxt = ST_LOAD_B;
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

  // Moore output map: controls that must be visible while in state st
  function automatic ctrl_t ctrl_of(input state_t st);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      ST_STORE:  c.d_wr = 1'b1;
      ST_LOAD_A: c.rf_sel = 1'b1;
      ST_LOAD_B: begin
        c.rf_sel  = 1'b1;
        c.rf_w_en = 1'b1;
      end
      ST_ADD: begin
        c.alu_s0  = ALU_ADD;
        c.rf_w_en = 1'b1;
      end
      ST_SUB: begin
        c.alu_s0  = ALU_SUB;
        c.rf_w_en = 1'b1;
      end
      ST_HALT:   c.halted = 1'b1;
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/datapath_controller_pc_ir_reg.sv
// rtl/datapath_controller_pc_ir_reg.sv - program counter and instruction register
module pc_ir_reg #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               PC_clr,
  input  logic               PC_up,
  input  logic               IR_ld,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir
);

  // Clear dominates; PC wraps naturally modulo 2^PC_W
  always_ff @(posedge clk) begin
    if (PC_clr) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (PC_up) pc <= pc + PC_W'(1);
      if (IR_ld) ir <= instr;
    end
  end

endmodule

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - Moore FSM sequencing the 16-bit datapath one instruction at a time
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] I_data,
  output logic [PC_W-1:0]    PC_addr,
  output logic [INSTR_W-1:0] IR_out,
  output logic [3:0]         state_out,
  output logic [7:0]         D_addr,
  output logic               D_wr,
  output logic               RF_sel,
  output logic               RF_W_en,
  output logic [3:0]         WriteAddr,
  output logic [3:0]         rdAddrA,
  output logic [3:0]         rdAddrB,
  output logic [2:0]         ALU_s0,
  output logic               halted
);

  state_t     state;
  ctrl_t      ctrl;
  logic       pc_clr;
  logic       pc_up;
  logic       ir_ld;
  logic [3:0] opcode;

  // IR captures I_data and PC advances on the edge that leaves FETCH
  assign pc_clr = reset;
  assign pc_up  = (state == ST_FETCH);
  assign ir_ld  = (state == ST_FETCH);

  pc_ir_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_pc_ir (
    .clk    (clk),
    .PC_clr (pc_clr),
    .PC_up  (pc_up),
    .IR_ld  (ir_ld),
    .instr  (I_data),
    .pc     (PC_addr),
    .ir     (IR_out)
  );

  assign opcode = IR_out[15:12];

  // Register fields decode straight from IR in every state
  assign rdAddrA   = IR_out[11:8];
  assign rdAddrB   = IR_out[7:4];
  assign WriteAddr = IR_out[3:0];
  assign D_addr    = (opcode == OP_STORE) ? IR_out[7:0] : IR_out[11:4];

  // FSM: controls are registered from the successor state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      ctrl  <= CTRL_IDLE;
    end else begin
      state <= next_state(state, opcode);
      ctrl  <= ctrl_of(next_state(state, opcode));
    end
  end

  assign state_out = state;
  assign D_wr      = ctrl.d_wr;
  assign RF_sel    = ctrl.rf_sel;
  assign RF_W_en   = ctrl.rf_w_en;
  assign ALU_s0    = ctrl.alu_s0;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - self-checking bench for datapath_controller
module tb_datapath_controller;
  import datapath_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] I_data;
  logic [6:0]  PC_addr;
  logic [15:0] IR_out;
  logic [3:0]  state_out;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_sel;
  logic        RF_W_en;
  logic [3:0]  WriteAddr;
  logic [3:0]  rdAddrA;
  logic [3:0]  rdAddrB;
  logic [2:0]  ALU_s0;
  logic        halted;

  logic [15:0] rom [0:127];
  int          tests = 0;
  int          failures = 0;
  int          pc_model;

  always #5 clk = ~clk;
  assign I_data = rom[PC_addr];

  datapath_controller dut (
    .clk       (clk),
    .reset     (reset),
    .I_data    (I_data),
    .PC_addr   (PC_addr),
    .IR_out    (IR_out),
    .state_out (state_out),
    .D_addr    (D_addr),
    .D_wr      (D_wr),
    .RF_sel    (RF_sel),
    .RF_W_en   (RF_W_en),
    .WriteAddr (WriteAddr),
    .rdAddrA   (rdAddrA),
    .rdAddrB   (rdAddrB),
    .ALU_s0    (ALU_s0),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full snapshot check of one cycle, sampled at the falling edge
  task automatic chk_cycle(input string tag, input state_t st, input logic dwr,
                           input logic rsel, input logic wen, input logic [2:0] alu,
                           input logic hlt, input int pc, input logic [15:0] ir);
    chk({tag, "/state"},   32'(state_out), 32'(st));
    chk({tag, "/D_wr"},    32'(D_wr),      32'(dwr));
    chk({tag, "/RF_sel"},  32'(RF_sel),    32'(rsel));
    chk({tag, "/RF_W_en"}, 32'(RF_W_en),   32'(wen));
    chk({tag, "/ALU_s0"},  32'(ALU_s0),    32'(alu));
    chk({tag, "/halted"},  32'(halted),    32'(hlt));
    chk({tag, "/PC"},      32'(PC_addr),   32'(pc % 128));
    chk({tag, "/IR"},      32'(IR_out),    32'(ir));
    chk({tag, "/rdA"},     32'(rdAddrA),   32'(ir[11:8]));
    chk({tag, "/rdB"},     32'(rdAddrB),   32'(ir[7:4]));
    chk({tag, "/wa"},      32'(WriteAddr), 32'(ir[3:0]));
    chk({tag, "/D_addr"},  32'(D_addr),    32'((ir[15:12] == 4'd1) ? ir[7:0] : ir[11:4]));
  endtask

  // Fetch and decode the instruction at pc_model, then check its execute cycles
  task automatic run_instr(input string tag, input logic [15:0] prev_ir);
    logic [15:0] ir;
    int          nxt;
    ir  = rom[pc_model];
    nxt = (pc_model + 1) % 128;
    @(negedge clk);
    chk_cycle({tag, "/fetch"}, ST_FETCH, 0, 0, 0, 3'd0, 0, pc_model, prev_ir);
    @(negedge clk);
    chk_cycle({tag, "/decode"}, ST_DECODE, 0, 0, 0, 3'd0, 0, nxt, ir);
    case (ir[15:12])
      4'd1: begin
        @(negedge clk); chk_cycle({tag, "/store"}, ST_STORE, 1, 0, 0, 3'd0, 0, nxt, ir);
      end
      4'd2: begin
        @(negedge clk); chk_cycle({tag, "/load_a"}, ST_LOAD_A, 0, 1, 0, 3'd0, 0, nxt, ir);
        @(negedge clk); chk_cycle({tag, "/load_b"}, ST_LOAD_B, 0, 1, 1, 3'd0, 0, nxt, ir);
      end
      4'd3: begin
        @(negedge clk); chk_cycle({tag, "/add"}, ST_ADD, 0, 0, 1, 3'b001, 0, nxt, ir);
      end
      4'd4: begin
        @(negedge clk); chk_cycle({tag, "/sub"}, ST_SUB, 0, 0, 1, 3'b010, 0, nxt, ir);
      end
      4'd5: begin
        for (int k = 0; k < 22; k++) begin
          @(negedge clk); chk_cycle({tag, "/halt"}, ST_HALT, 0, 0, 0, 3'd0, 1, nxt, ir);
        end
      end
      default: begin
        @(negedge clk); chk_cycle({tag, "/noop"}, ST_NOOP, 0, 0, 0, 3'd0, 0, nxt, ir);
      end
    endcase
    pc_model = nxt;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_cycle(tag, ST_INIT, 0, 0, 0, 3'd0, 0, 0, 16'h0000);
    end
    reset = 1'b0;
    pc_model = 0;
  endtask

  initial begin
    logic [15:0] last_ir;
    logic [31:0] r;
    int          op;

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2011;
    rom[1] = 16'h116A;
    rom[2] = 16'h3123;
    rom[3] = 16'h4210;
    rom[4] = 16'hB000;
    rom[5] = 16'h5000;

    // Directed program: LOAD, STORE, ADD, SUB, undefined, HALT
    apply_reset("rst0");
    run_instr("load",  16'h0000);
    run_instr("store", 16'h2011);
    run_instr("add",   16'h116A);
    run_instr("sub",   16'h3123);
    run_instr("undef", 16'h4210);
    run_instr("halt",  16'hB000);

    // Reset recovers from HALT
    apply_reset("rst_halt");

    // Reset asserted at an edge while in LOAD_A
    @(negedge clk);
    chk("mid/fetch", 32'(state_out), 32'(ST_FETCH));
    @(negedge clk);
    chk("mid/decode", 32'(state_out), 32'(ST_DECODE));
    @(negedge clk);
    chk("mid/load_a", 32'(state_out), 32'(ST_LOAD_A));
    apply_reset("rst_load_a");

    // Random program, long enough to wrap PC past 127; ROM[127] is a NOOP
    for (int i = 0; i < 128; i++) begin
      op = int'($urandom_range(0, 14));
      if (op >= 5) op = op + 1;
      r = $urandom();
      rom[i] = {4'(op), r[11:0]};
    end
    rom[127] = 16'h0000;
    last_ir = 16'h0000;
    for (int n = 0; n < 131; n++) begin
      run_instr("rand", last_ir);
      last_ir = rom[(pc_model + 127) % 128];
      if (pc_model == 0) chk("pc_wrap", 32'(PC_addr), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
